// File: rtl/mem_pkg.sv
// Shared definitions for the two-master cache-line memory arbiter:
// FSM state encoding, requester owner IDs and the cache line width.
package mem_pkg;

    // Width of one cache line moved per memory transaction.
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT0  = 2'd1,
        ST_GRANT1  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // m0 is the dcache, m1 is the icache.
    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_t;

    // Grant state that serves a given owner.
    function automatic arb_state_t grant_state(owner_t owner);
        return (owner == OWNER_M0) ? ST_GRANT0 : ST_GRANT1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the data-memory port and the error flag.
// The slave modport is the arbiter's view; the master modport is the
// view of whatever drives the caches and the memory (e.g. a bench).
interface mem_arbiter_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = LINE_W
);

    // Requester 0 (dcache)
    logic              m0_enable_i;
    logic              m0_write_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_data_i;
    logic              m0_ack_o;
    logic [DATA_W-1:0] m0_data_o;

    // Requester 1 (icache)
    logic              m1_enable_i;
    logic              m1_write_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_data_i;
    logic              m1_ack_o;
    logic [DATA_W-1:0] m1_data_o;

    // Data memory
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;

    // Sticky protocol / timeout error
    logic              err_o;

    modport slave (
        input  m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
        output m0_ack_o, m0_data_o,
        input  m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
        output m1_ack_o, m1_data_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_ack_i, mem_data_i,
        output err_o
    );

    modport master (
        output m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
        input  m0_ack_o, m0_data_o,
        output m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
        input  m1_ack_o, m1_data_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_ack_i, mem_data_i,
        input  err_o
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the
// requester that was not served last wins.
module rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic       gnt_vld,
    output owner_t     gnt
);

    // Combinational pick from the request vector and the last-served pointer.
    always_comb begin
        gnt_vld = |req;
        gnt     = OWNER_M0;
        if (req == 2'b11) begin
            gnt = (last == OWNER_M0) ? OWNER_M1 : OWNER_M0;
        end else if (req[1]) begin
            gnt = OWNER_M1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between dcache (m0) and icache (m1) for a single data memory.
// One transaction at a time; a grant is held until the memory acks, then
// one RELEASE cycle with the memory port idle precedes the next arbitration.
// A watchdog flags transactions that wait TIMEOUT_CYC cycles, and any ack
// arriving outside a grant is flagged as a protocol error.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = LINE_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    arb_state_t       state_q, state_d;
    owner_t           ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             pick_vld;
    owner_t           pick;

    rr_arb2 u_rr_arb2 (
        .req     ({bus.m1_enable_i, bus.m0_enable_i}),
        .last    (ptr_q),
        .gnt_vld (pick_vld),
        .gnt     (pick)
    );

    // Control state; asynchronous reset abandons any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= OWNER_M1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state, round-robin pointer, watchdog counter and sticky error.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                // Counter is cleared here so it starts at zero on grant entry.
                cnt_d = '0;
                if (bus.mem_ack_i) err_d = 1'b1;
                if (pick_vld) state_d = grant_state(pick);
            end
            ST_GRANT0, ST_GRANT1: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_MAX) err_d = 1'b1;
                if (bus.mem_ack_i) begin
                    ptr_d   = (state_q == ST_GRANT0) ? OWNER_M0 : OWNER_M1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (bus.mem_ack_i) err_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-port mux and completion pulses, driven straight from the state.
    always_comb begin
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_data_o   = '0;
        bus.m0_ack_o     = 1'b0;
        bus.m1_ack_o     = 1'b0;
        case (state_q)
            ST_GRANT0: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = bus.m0_write_i;
                bus.mem_addr_o   = bus.m0_addr_i;
                bus.mem_data_o   = bus.m0_data_i;
                bus.m0_ack_o     = bus.mem_ack_i;
            end
            ST_GRANT1: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = bus.m1_write_i;
                bus.mem_addr_o   = bus.m1_addr_i;
                bus.mem_data_o   = bus.m1_data_i;
                bus.m1_ack_o     = bus.mem_ack_i;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; each master qualifies it with its own ack.
    assign bus.m0_data_o = bus.mem_data_i;
    assign bus.m1_data_o = bus.mem_data_i;
    assign bus.err_o     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, round-robin ties,
// write while the other master waits, enable drop, reset mid-transaction,
// watchdog timeout and spurious memory ack.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;
    localparam int TMO    = 64;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    int   total = 0;
    int   bad = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.m0_enable_i = 1'b0; bus.m0_write_i = 1'b0; bus.m0_addr_i = '0; bus.m0_data_i = '0;
        bus.m1_enable_i = 1'b0; bus.m1_write_i = 1'b0; bus.m1_addr_i = '0; bus.m1_data_i = '0;
        bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL rst_mem_enable got=%b exp=0", bus.mem_enable_o); end
        total++; if (bus.mem_write_o !== 1'b0) begin bad++; $display("FAIL rst_mem_write got=%b exp=0", bus.mem_write_o); end
        total++; if (bus.mem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr_o); end
        total++; if (bus.m0_ack_o !== 1'b0) begin bad++; $display("FAIL rst_m0_ack got=%b exp=0", bus.m0_ack_o); end
        total++; if (bus.m1_ack_o !== 1'b0) begin bad++; $display("FAIL rst_m1_ack got=%b exp=0", bus.m1_ack_o); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err_o); end
        rst_i = 1'b1;
        tick();
        total++; if (bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL rst_idle_enable got=%b exp=0", bus.mem_enable_o); end
    endtask

    task automatic test_single_read;
        logic [DATA_W-1:0] rd;
        int en_cnt;
        rd = {8{32'h1234_5678}};
        en_cnt = 0;
        bus.m0_enable_i = 1'b1; bus.m0_write_i = 1'b0; bus.m0_addr_i = 32'h0000_0400;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin bus.mem_ack_i = 1'b1; bus.mem_data_i = rd; end
            #1;
            if (bus.mem_enable_o === 1'b1) en_cnt++;
            if (i < 9) begin
                total++; if (bus.m0_ack_o !== 1'b0) begin bad++; $display("FAIL rd_early_ack cyc=%0d got=%b exp=0", i, bus.m0_ack_o); end
            end else begin
                total++; if (bus.m0_ack_o !== 1'b1) begin bad++; $display("FAIL rd_m0_ack got=%b exp=1", bus.m0_ack_o); end
                total++; if (bus.m0_data_o !== rd) begin bad++; $display("FAIL rd_m0_data got=%h exp=%h", bus.m0_data_o, rd); end
                total++; if (bus.m1_ack_o !== 1'b0) begin bad++; $display("FAIL rd_m1_ack got=%b exp=0", bus.m1_ack_o); end
                total++; if (bus.mem_addr_o !== 32'h0000_0400) begin bad++; $display("FAIL rd_addr got=%h exp=00000400", bus.mem_addr_o); end
                bus.m0_enable_i = 1'b0;
            end
            tick();
        end
        bus.mem_ack_i = 1'b0;
        #1;
        total++; if (en_cnt != 10) begin bad++; $display("FAIL rd_enable_cycles got=%0d exp=10", en_cnt); end
        total++; if (bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL rd_release_enable got=%b exp=0", bus.mem_enable_o); end
        total++; if (bus.m0_ack_o !== 1'b0) begin bad++; $display("FAIL rd_release_ack got=%b exp=0", bus.m0_ack_o); end
        tick();
    endtask

    task automatic test_tie;
        do_reset();
        bus.m0_enable_i = 1'b1; bus.m0_addr_i = 32'h0000_0100;
        bus.m1_enable_i = 1'b1; bus.m1_addr_i = 32'h0000_0200;
        tick();
        #1;
        total++; if (bus.mem_addr_o !== 32'h0000_0100) begin bad++; $display("FAIL tie_first_m0 got=%h exp=00000100", bus.mem_addr_o); end
        bus.mem_ack_i = 1'b1;
        #1;
        total++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b10) begin bad++; $display("FAIL tie_ack_m0 got=%b exp=10", {bus.m0_ack_o, bus.m1_ack_o}); end
        tick();
        bus.mem_ack_i = 1'b0;
        #1;
        total++; if (bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL tie_release got=%b exp=0", bus.mem_enable_o); end
        tick();
        total++; if (bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL tie_idle got=%b exp=0", bus.mem_enable_o); end
        tick();
        total++; if (bus.mem_enable_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_0200) begin bad++; $display("FAIL tie_second_m1 got=%b/%h exp=1/00000200", bus.mem_enable_o, bus.mem_addr_o); end
        bus.mem_ack_i = 1'b1;
        #1;
        total++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b01) begin bad++; $display("FAIL tie_ack_m1 got=%b exp=01", {bus.m0_ack_o, bus.m1_ack_o}); end
        tick();
        bus.mem_ack_i = 1'b0;
        tick();
        tick();
        total++; if (bus.mem_addr_o !== 32'h0000_0100) begin bad++; $display("FAIL tie_third_m0 got=%h exp=00000100", bus.mem_addr_o); end
        bus.mem_ack_i = 1'b1;
        bus.m0_enable_i = 1'b0; bus.m1_enable_i = 1'b0;
        #1;
        total++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b10) begin bad++; $display("FAIL tie_ack_m0_again got=%b exp=10", {bus.m0_ack_o, bus.m1_ack_o}); end
        tick();
        bus.mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_write_priority;
        logic [DATA_W-1:0] wd;
        wd = {32{8'hA5}};
        bus.m1_enable_i = 1'b1; bus.m1_write_i = 1'b1; bus.m1_addr_i = 32'h0000_0800; bus.m1_data_i = wd;
        tick();
        bus.m0_enable_i = 1'b1; bus.m0_write_i = 1'b0; bus.m0_addr_i = 32'h0000_0300; bus.m0_data_i = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.mem_write_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_0800 || bus.mem_data_o !== wd || bus.m0_ack_o !== 1'b0) begin
                bad++; $display("FAIL wr_hold cyc=%0d got wr=%b addr=%h ack0=%b exp wr=1 addr=00000800 ack0=0", i, bus.mem_write_o, bus.mem_addr_o, bus.m0_ack_o);
            end
            tick();
        end
        bus.mem_ack_i = 1'b1;
        bus.m1_enable_i = 1'b0;
        #1;
        total++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b01) begin bad++; $display("FAIL wr_ack_m1 got=%b exp=01", {bus.m0_ack_o, bus.m1_ack_o}); end
        tick();
        bus.mem_ack_i = 1'b0;
        tick();
        tick();
        total++; if (bus.mem_addr_o !== 32'h0000_0300 || bus.mem_write_o !== 1'b0) begin bad++; $display("FAIL wr_then_m0 got=%h/%b exp=00000300/0", bus.mem_addr_o, bus.mem_write_o); end
        bus.mem_ack_i = 1'b1;
        bus.m0_enable_i = 1'b0;
        #1;
        total++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b10) begin bad++; $display("FAIL wr_ack_m0 got=%b exp=10", {bus.m0_ack_o, bus.m1_ack_o}); end
        tick();
        bus.mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_drop_enable;
        logic [DATA_W-1:0] rd;
        rd = {4{64'hDEAD_BEEF_0BAD_F00D}};
        bus.m0_enable_i = 1'b1; bus.m0_addr_i = 32'h0000_0500;
        tick();
        bus.m0_enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.mem_enable_o !== 1'b1) begin bad++; $display("FAIL drop_hold cyc=%0d got=%b exp=1", i, bus.mem_enable_o); end
            tick();
        end
        bus.mem_ack_i = 1'b1; bus.mem_data_i = rd;
        #1;
        total++; if (bus.m0_ack_o !== 1'b1 || bus.m0_data_o !== rd) begin bad++; $display("FAIL drop_ack got=%b exp=1", bus.m0_ack_o); end
        tick();
        bus.mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        bus.m0_enable_i = 1'b1; bus.m0_addr_i = 32'h0000_0600;
        tick();
        total++; if (bus.mem_enable_o !== 1'b1) begin bad++; $display("FAIL rmid_granted got=%b exp=1", bus.mem_enable_o); end
        rst_i = 1'b0;
        #1;
        total++; if (bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL rmid_enable_drop got=%b exp=0", bus.mem_enable_o); end
        bus.m0_enable_i = 1'b0;
        bus.mem_ack_i = 1'b1;
        #1;
        total++; if (bus.m0_ack_o !== 1'b0) begin bad++; $display("FAIL rmid_ack_in_reset got=%b exp=0", bus.m0_ack_o); end
        tick();
        rst_i = 1'b1;
        #1;
        total++; if (bus.m0_ack_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL rmid_late_ack got ack=%b en=%b exp 0/0", bus.m0_ack_o, bus.mem_enable_o); end
        tick();
        bus.mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        int early;
        do_reset();
        bus.m0_enable_i = 1'b1; bus.m0_addr_i = 32'h0000_0700;
        tick();
        early = 0;
        for (int i = 1; i < TMO; i++) begin
            tick();
            if (bus.err_o !== 1'b0) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL tmo_early_err got=%0d cycles exp=0", early); end
        tick();
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL tmo_err_at_limit got=%b exp=1", bus.err_o); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (bus.err_o !== 1'b1 || bus.mem_enable_o !== 1'b1) begin bad++; $display("FAIL tmo_wait cyc=%0d got err=%b en=%b exp 1/1", i, bus.err_o, bus.mem_enable_o); end
        end
        bus.mem_ack_i = 1'b1; bus.m0_enable_i = 1'b0;
        #1;
        total++; if (bus.m0_ack_o !== 1'b1) begin bad++; $display("FAIL tmo_late_ack got=%b exp=1", bus.m0_ack_o); end
        tick();
        bus.mem_ack_i = 1'b0;
        tick();
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b exp=1", bus.err_o); end
    endtask

    task automatic test_spurious_ack;
        do_reset();
        bus.mem_ack_i = 1'b1;
        #1;
        total++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b00) begin bad++; $display("FAIL spur_no_ack got=%b exp=00", {bus.m0_ack_o, bus.m1_ack_o}); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL spur_err_before got=%b exp=0", bus.err_o); end
        tick();
        bus.mem_ack_i = 1'b0;
        #1;
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL spur_err got=%b exp=1", bus.err_o); end
        repeat (3) tick();
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%b exp=1", bus.err_o); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_write_priority();
        test_drop_enable();
        test_reset_mid();
        test_timeout();
        test_spurious_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
